i2c_line_conditioner: RTL

//  Upstream front end for the I2C subordinate. Samples raw SDA/SCL pads on CLOCK_50 and emits

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_line_conditioner_if.sv | 31 +++
 rtl/i2c_glitch_filter.sv | 49 ++++
 rtl/i2c_line_conditioner.sv | 102 ++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared defaults and width helper for the I2C line conditioner
package i2c_pkg;

    localparam int I2C_SYNC_DEF        = 2;
    localparam int I2C_FILT_CYCLES_DEF = 3;
    localparam int I2C_TIMEOUT_DEF     = 1_750_000;

    // Bits needed to hold 0..n-1, never less than 1 so a counter always exists.
    function automatic int clog2_sat(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/i2c_line_conditioner_if.sv
// rtl/i2c_line_conditioner_if.sv - pad inputs and conditioned line outputs
//   scl_raw/sda_raw          : asynchronous pad levels into the conditioner
//   scl_clean/sda_clean      : filtered line levels
//   scl_rise/scl_fall        : 1-clk SCL edge strobes
//   start_det/stop_det       : 1-clk START (incl. repeated) / STOP strobes
//   bus_busy                 : high between START and STOP/timeout
//   timeout                  : 1-clk strobe, SCL stuck low while busy
interface i2c_line_conditioner_if;
    logic scl_raw;
    logic sda_raw;
    logic scl_clean;
    logic sda_clean;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic bus_busy;
    logic timeout;

    modport master (
        output scl_raw, sda_raw,
        input  scl_clean, sda_clean, scl_rise, scl_fall,
               start_det, stop_det, bus_busy, timeout
    );

    modport slave (
        input  scl_raw, sda_raw,
        output scl_clean, sda_clean, scl_rise, scl_fall,
               start_det, stop_det, bus_busy, timeout
    );
endinterface

// File: rtl/i2c_glitch_filter.sv
// rtl/i2c_glitch_filter.sv - synchroniser plus stable-count spike filter for one line
//   clk, rst_n : system clock, asynchronous active-low reset
//   d_raw      : asynchronous pad level
//   q_clean    : filtered level, resets high (idle bus)
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_DEF,
    parameter int FILT_CYCLES = I2C_FILT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_raw,
    output logic q_clean
);
    localparam int            CW       = clog2_sat(FILT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Chain resets to 1 so an idle-high pad produces no edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_raw};
        end
    end

    // A new level must differ from the clean level for FILT_CYCLES consecutive
    // cycles; any return to the clean level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            q_clean <= 1'b1;
        end else if (synced == q_clean) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            q_clean <= synced;
            cnt     <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_line_conditioner.sv
// rtl/i2c_line_conditioner.sv - clean SCL/SDA, edge and START/STOP strobes, busy and timeout
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : slave side of i2c_line_conditioner_if (raw pads in, conditioned lines out)
module i2c_line_conditioner
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES    = I2C_SYNC_DEF,
    parameter int FILT_CYCLES    = I2C_FILT_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = I2C_TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    i2c_line_conditioner_if.slave   bus
);
    localparam int            TW      = clog2_sat(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          scl_c;
    logic          sda_c;
    logic          sclq;
    logic          sdaq;
    logic          busy;
    logic          start_c;
    logic          stop_c;
    logic          to_hit;
    logic [TW-1:0] to_cnt;
    logic          scl_rise_q;
    logic          scl_fall_q;
    logic          start_q;
    logic          stop_q;
    logic          timeout_q;

    i2c_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES)
    ) u_scl_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_raw   (bus.scl_raw),
        .q_clean (scl_c)
    );

    i2c_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES)
    ) u_sda_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_raw   (bus.sda_raw),
        .q_clean (sda_c)
    );

    // SCL must be high both before and after the SDA change, so an SDA change
    // landing in the same cycle as an SCL change is never a START/STOP.
    assign start_c = sclq & scl_c &  sdaq & ~sda_c;
    assign stop_c  = sclq & scl_c & ~sdaq &  sda_c;
    assign to_hit  = busy & ~scl_c & (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclq       <= 1'b1;
            sdaq       <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            timeout_q  <= 1'b0;
            busy       <= 1'b0;
            to_cnt     <= '0;
        end else begin
            sclq       <= scl_c;
            sdaq       <= sda_c;
            scl_rise_q <=  scl_c & ~sclq;
            scl_fall_q <= ~scl_c &  sclq;
            start_q    <= start_c;
            stop_q     <= stop_c;
            timeout_q  <= to_hit;

            if (to_hit || stop_c) begin
                busy <= 1'b0;
            end else if (start_c) begin
                busy <= 1'b1;
            end

            // Saturates at the terminal value; busy drops on the hit, so no re-fire.
            if (scl_c || !busy) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_LAST) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign bus.scl_clean = scl_c;
    assign bus.sda_clean = sda_c;
    assign bus.scl_rise  = scl_rise_q;
    assign bus.scl_fall  = scl_fall_q;
    assign bus.start_det = start_q;
    assign bus.stop_det  = stop_q;
    assign bus.bus_busy  = busy;
    assign bus.timeout   = timeout_q;
endmodule
